// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory request/response, hazard/branch
// controls in, and the IF/ID register out.
interface fetch_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_instr;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data,
    input  stall,
    input  redirect_valid,
    input  redirect_pc,
    output id_valid,
    output id_pc,
    output id_pc_plus4,
    output id_instr
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data,
    output stall,
    output redirect_valid,
    output redirect_pc,
    input  id_valid,
    input  id_pc,
    input  id_pc_plus4,
    input  id_instr
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC register, single-outstanding imem fetch and the
// IF/ID pipeline register, with stall hold and branch redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic           clk,
  input logic           rst,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {StReq, StWait, StHold} state_e;

  localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

  state_e      r_state, w_state_d;
  logic [31:0] r_pc, w_pc_d;
  logic [31:0] r_req_pc, w_req_pc_d;
  logic        r_kill, w_kill_d;
  logic [31:0] r_buf_pc, w_buf_pc_d;
  logic [31:0] r_buf_instr, w_buf_instr_d;
  logic        r_id_valid, w_id_valid_d;
  logic [31:0] r_id_pc, w_id_pc_d;
  logic [31:0] r_id_pc_plus4, w_id_pc_plus4_d;
  logic [31:0] r_id_instr, w_id_instr_d;

  logic        w_req_valid;
  logic        w_accept;
  logic        w_load;
  logic [31:0] w_load_pc;
  logic [31:0] w_load_instr;

  assign w_req_valid = (r_state == StReq) && !rst;
  assign w_accept    = w_req_valid && bus.imem_req_ready;

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = {r_pc[31:2], 2'b00};
  assign bus.id_valid       = r_id_valid;
  assign bus.id_pc          = r_id_pc;
  assign bus.id_pc_plus4    = r_id_pc_plus4;
  assign bus.id_instr       = r_id_instr;

  always_comb begin
    w_state_d     = r_state;
    w_pc_d        = r_pc;
    w_req_pc_d    = r_req_pc;
    w_kill_d      = r_kill;
    w_buf_pc_d    = r_buf_pc;
    w_buf_instr_d = r_buf_instr;
    w_load        = 1'b0;
    w_load_pc     = r_req_pc;
    w_load_instr  = bus.imem_resp_data;

    if (bus.redirect_valid) begin
      // Redirect beats stall and any response; in-flight fetches become stale.
      w_pc_d = {bus.redirect_pc[31:2], 2'b00};
      case (r_state)
        StReq: begin
          if (w_accept) begin
            w_req_pc_d = r_pc;
            w_kill_d   = 1'b1;
            w_state_d  = StWait;
          end
        end
        StWait: begin
          if (bus.imem_resp_valid) begin
            w_kill_d  = 1'b0;
            w_state_d = StReq;
          end else begin
            w_kill_d = 1'b1;
          end
        end
        default: w_state_d = StReq;
      endcase
    end else begin
      case (r_state)
        StReq: begin
          if (w_accept) begin
            w_req_pc_d = r_pc;
            w_pc_d     = r_pc + 32'd4;
            w_state_d  = StWait;
          end
        end
        StWait: begin
          if (bus.imem_resp_valid) begin
            if (r_kill) begin
              w_kill_d  = 1'b0;
              w_state_d = StReq;
            end else if (!bus.stall || !r_id_valid) begin
              w_load    = 1'b1;
              w_state_d = StReq;
            end else begin
              w_buf_pc_d    = r_req_pc;
              w_buf_instr_d = bus.imem_resp_data;
              w_state_d     = StHold;
            end
          end
        end
        StHold: begin
          if (!bus.stall) begin
            w_load       = 1'b1;
            w_load_pc    = r_buf_pc;
            w_load_instr = r_buf_instr;
            w_state_d    = StReq;
          end
        end
        default: w_state_d = StReq;
      endcase
    end
  end

  always_comb begin
    w_id_valid_d    = r_id_valid;
    w_id_pc_d       = r_id_pc;
    w_id_pc_plus4_d = r_id_pc_plus4;
    w_id_instr_d    = r_id_instr;
    if (bus.redirect_valid) begin
      w_id_valid_d = 1'b0;
      w_id_instr_d = NOP_INSTR;
    end else if (w_load) begin
      w_id_valid_d    = 1'b1;
      w_id_pc_d       = w_load_pc;
      w_id_pc_plus4_d = w_load_pc + 32'd4;
      w_id_instr_d    = w_load_instr;
    end else if (!bus.stall) begin
      w_id_valid_d = 1'b0;
      w_id_instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StReq;
      r_pc          <= ResetPcAligned;
      r_req_pc      <= ResetPcAligned;
      r_kill        <= 1'b0;
      r_buf_pc      <= 32'd0;
      r_buf_instr   <= NOP_INSTR;
      r_id_valid    <= 1'b0;
      r_id_pc       <= 32'd0;
      r_id_pc_plus4 <= 32'd0;
      r_id_instr    <= NOP_INSTR;
    end else begin
      r_state       <= w_state_d;
      r_pc          <= w_pc_d;
      r_req_pc      <= w_req_pc_d;
      r_kill        <= w_kill_d;
      r_buf_pc      <= w_buf_pc_d;
      r_buf_instr   <= w_buf_instr_d;
      r_id_valid    <= w_id_valid_d;
      r_id_pc       <= w_id_pc_d;
      r_id_pc_plus4 <= w_id_pc_plus4_d;
      r_id_instr    <= w_id_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then randomized traffic, checked
// against a program-order fetch-stream model and a latency-programmable memory.
module tb_fetch_stage;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst_b;

  fetch_stage_if bus ();
  fetch_stage_if bus_b ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  fetch_stage #(.RESET_PC(WRAP_PC), .NOP_INSTR(NOP)) dut_b (
    .clk(clk),
    .rst(rst_b),
    .bus(bus_b)
  );

  int checks = 0;
  int errors = 0;

  // Stimulus controls for the next cycle
  logic        g_rst, g_ready, g_stall, g_redir;
  logic [31:0] g_redir_pc;
  int          g_delay;

  // Memory model: at most one accepted request awaiting its response
  bit          pend;
  logic [31:0] pend_addr;
  int          pend_cnt;

  // Fetch-stream model: next address to request, next PC expected in IF/ID
  logic [31:0] exp_req, exp_pc;
  int          entries;

  // Values seen during the cycle just completed
  logic        s_req_valid, s_acc, s_stall, s_id_valid;
  logic [31:0] s_req_addr, s_id_pc, s_id_plus4, s_id_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hAAAA_0001 + (a >> 2);
  endfunction

  function automatic logic [31:0] b32(input logic b);
    return {31'd0, b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic resp;
    resp = pend && (pend_cnt == 0);
    rst                 = g_rst;
    bus.imem_req_ready  = g_ready;
    bus.imem_resp_valid = resp;
    bus.imem_resp_data  = resp ? mem_word(pend_addr) : 32'hDEAD_BEEF;
    bus.stall           = g_stall;
    bus.redirect_valid  = g_redir;
    bus.redirect_pc     = g_redir_pc;
    #1;
    s_req_valid = bus.imem_req_valid;
    s_req_addr  = bus.imem_req_addr;
    s_acc       = s_req_valid && g_ready;
    s_stall     = g_stall;
    s_id_valid  = bus.id_valid;
    s_id_pc     = bus.id_pc;
    s_id_plus4  = bus.id_pc_plus4;
    s_id_instr  = bus.id_instr;
    chk("addr_align", {30'd0, s_req_addr[1:0]}, 32'd0);
    if (g_rst) chk("req_valid_in_rst", b32(s_req_valid), 32'd0);
    else if (pend) chk("one_outstanding", b32(s_req_valid), 32'd0);
    else if (s_req_valid) chk("req_addr_order", s_req_addr, exp_req);

    @(posedge clk);
    #1;
    if (g_rst) begin
      pend = 1'b0;
    end else begin
      if (resp) pend = 1'b0;
      else if (pend) pend_cnt--;
      if (s_acc) begin
        pend      = 1'b1;
        pend_addr = s_req_addr;
        pend_cnt  = g_delay;
      end
    end

    if (g_rst) begin
      exp_req = 32'd0;
      exp_pc  = 32'd0;
      chk("rst_id_valid", b32(bus.id_valid), 32'd0);
      chk("rst_id_pc", bus.id_pc, 32'd0);
      chk("rst_id_pc_plus4", bus.id_pc_plus4, 32'd0);
      chk("rst_id_instr", bus.id_instr, NOP);
    end else if (g_redir) begin
      exp_req = {g_redir_pc[31:2], 2'b00};
      exp_pc  = exp_req;
      chk("redir_id_valid", b32(bus.id_valid), 32'd0);
      chk("redir_id_instr", bus.id_instr, NOP);
    end else begin
      if (s_acc) exp_req = s_req_addr + 32'd4;
      if (s_stall && s_id_valid) begin
        chk("hold_valid", b32(bus.id_valid), 32'd1);
        chk("hold_pc", bus.id_pc, s_id_pc);
        chk("hold_plus4", bus.id_pc_plus4, s_id_plus4);
        chk("hold_instr", bus.id_instr, s_id_instr);
      end else if (bus.id_valid) begin
        chk("entry_pc", bus.id_pc, exp_pc);
        chk("entry_plus4", bus.id_pc_plus4, exp_pc + 32'd4);
        chk("entry_instr", bus.id_instr, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        entries++;
      end else begin
        chk("bubble_instr", bus.id_instr, NOP);
      end
    end
  endtask

  initial begin
    rst_b                 = 1'b1;
    bus_b.imem_req_ready  = 1'b1;
    bus_b.imem_resp_valid = 1'b0;
    bus_b.imem_resp_data  = 32'd0;
    bus_b.stall           = 1'b0;
    bus_b.redirect_valid  = 1'b0;
    bus_b.redirect_pc     = 32'd0;

    g_rst = 1'b1; g_ready = 1'b1; g_delay = 0; g_stall = 1'b0; g_redir = 1'b0;
    g_redir_pc = 32'd0;
    pend = 1'b0; pend_addr = 32'd0; pend_cnt = 0;
    exp_req = 32'd0; exp_pc = 32'd0; entries = 0;

    tick();
    tick();
    chk("rst_req_valid_low", b32(bus.imem_req_valid), 32'd0);

    // Memory not ready for 3 cycles: address must stay put
    g_rst = 1'b0; g_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("unacc_req_valid", b32(s_req_valid), 32'd1);
      chk("unacc_req_addr", s_req_addr, 32'h0);
      chk("unacc_id_valid", b32(bus.id_valid), 32'd0);
    end
    g_ready = 1'b1; g_delay = 2;
    tick();
    chk("accept_addr0", s_req_addr, 32'h0);
    repeat (2) begin
      tick();
      chk("wait_no_dup_req", b32(s_req_valid), 32'd0);
      chk("wait_no_id", b32(bus.id_valid), 32'd0);
    end
    tick();
    chk("first_id_valid", b32(bus.id_valid), 32'd1);
    chk("first_id_pc", bus.id_pc, 32'h0);
    chk("first_id_instr", bus.id_instr, 32'hAAAA_0001);
    chk("first_id_plus4", bus.id_pc_plus4, 32'h4);

    // Zero-wait memory: one instruction per two cycles with a bubble between
    g_delay = 0;
    tick();
    chk("req_addr4", s_req_addr, 32'h4);
    chk("bubble_valid", b32(bus.id_valid), 32'd0);
    tick();
    chk("second_id_pc", bus.id_pc, 32'h4);
    chk("second_id_instr", bus.id_instr, 32'hAAAA_0002);

    // Stall while the response for 0x8 arrives
    g_stall = 1'b1;
    tick();
    chk("req_addr8", s_req_addr, 32'h8);
    tick();
    chk("hold_no_req", b32(bus.imem_req_valid), 32'd0);
    chk("hold_keeps_pc4", bus.id_pc, 32'h4);
    tick();
    chk("hold_no_req2", b32(s_req_valid), 32'd0);
    g_stall = 1'b0;
    tick();
    chk("unstall_id_valid", b32(bus.id_valid), 32'd1);
    chk("unstall_id_pc", bus.id_pc, 32'h8);
    chk("unstall_id_instr", bus.id_instr, 32'hAAAA_0003);
    tick();
    chk("after_hold_req", b32(s_req_valid), 32'd1);
    chk("after_hold_addr", s_req_addr, 32'hC);
    tick();
    chk("id_pc_c", bus.id_pc, 32'hC);

    // Redirect to 0x103 while waiting on 0x10
    g_delay = 2;
    tick();
    chk("req_addr10", s_req_addr, 32'h10);
    g_redir = 1'b1; g_redir_pc = 32'h103;
    tick();
    chk("redir_wait_id", b32(bus.id_valid), 32'd0);
    g_redir = 1'b0;
    repeat (2) begin
      tick();
      chk("killed_wait_no_req", b32(s_req_valid), 32'd0);
      chk("killed_wait_id", b32(bus.id_valid), 32'd0);
    end
    g_delay = 0;
    tick();
    chk("redir_target_req", b32(s_req_valid), 32'd1);
    chk("redir_target_addr", s_req_addr, 32'h100);
    tick();
    chk("redir_first_valid", b32(bus.id_valid), 32'd1);
    chk("redir_first_pc", bus.id_pc, 32'h100);

    // Redirect together with stall flushes a live IF/ID
    g_stall = 1'b1; g_redir = 1'b1; g_redir_pc = 32'h200;
    tick();
    chk("redir_stall_valid", b32(bus.id_valid), 32'd0);
    chk("redir_stall_instr", bus.id_instr, NOP);
    g_stall = 1'b0; g_redir = 1'b0;
    tick();
    chk("stale_resp_dropped", b32(bus.id_valid), 32'd0);
    tick();
    chk("req_addr200", s_req_addr, 32'h200);

    // Redirect in the same WAIT cycle as the response
    g_redir = 1'b1; g_redir_pc = 32'h300;
    tick();
    chk("redir_resp_same", b32(bus.id_valid), 32'd0);
    g_redir = 1'b0;
    tick();
    chk("redir_resp_req", b32(s_req_valid), 32'd1);
    chk("redir_resp_addr", s_req_addr, 32'h300);

    // Reset pulsed while waiting
    g_rst = 1'b1;
    tick();
    g_rst = 1'b0;
    tick();
    chk("post_rst_req", b32(s_req_valid), 32'd1);
    chk("post_rst_addr", s_req_addr, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      g_ready    = ($urandom_range(0, 3) != 0);
      g_delay    = $urandom_range(0, 3);
      g_stall    = ($urandom_range(0, 9) < 3);
      g_redir    = ($urandom_range(0, 29) == 0);
      g_redir_pc = $urandom();
      g_rst      = ($urandom_range(0, 199) == 0);
      tick();
    end
    g_rst = 1'b0; g_stall = 1'b0; g_redir = 1'b0;
    chk("progress", b32(entries > 100), 32'd1);

    // PC wrap from the top of the address space
    rst_b = 1'b0;
    #1;
    chk("wrap_first_req", b32(bus_b.imem_req_valid), 32'd1);
    chk("wrap_first_addr", bus_b.imem_req_addr, WRAP_PC);
    @(posedge clk);
    #1;
    chk("wrap_wait", b32(bus_b.imem_req_valid), 32'd0);
    bus_b.imem_resp_valid = 1'b1;
    bus_b.imem_resp_data  = 32'h1234_5678;
    @(posedge clk);
    #1;
    bus_b.imem_resp_valid = 1'b0;
    chk("wrap_id_pc", bus_b.id_pc, WRAP_PC);
    chk("wrap_id_plus4", bus_b.id_pc_plus4, 32'h0);
    chk("wrap_id_instr", bus_b.id_instr, 32'h1234_5678);
    chk("wrap_next_req", b32(bus_b.imem_req_valid), 32'd1);
    chk("wrap_next_addr", bus_b.imem_req_addr, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
